// File: rtl/afg_sweep_pkg.sv
// Shared definitions for the frequency sweep controller: FSM state
// encoding and the default word widths.
package afg_sweep_pkg;

    localparam int FW_DEFAULT = 48;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/sweep_next_freq.sv
// Combinational next-point calculator. Steps the current frequency word
// toward the stop word and clamps to the stop word on wrap or overshoot.
module sweep_next_freq #(
    parameter int FW = 48
) (
    input  logic [FW-1:0] cur_i,
    input  logic [FW-1:0] step_i,
    input  logic [FW-1:0] stop_i,
    input  logic          dir_up_i,
    output logic [FW-1:0] next_o,
    output logic          last_o
);

    logic [FW:0] sum_w;
    logic [FW:0] diff_w;

    // The extra top bit carries the carry-out (up) or borrow (down).
    assign sum_w  = {1'b0, cur_i} + {1'b0, step_i};
    assign diff_w = {1'b0, cur_i} - {1'b0, step_i};

    // A zero step can never reach the stop word, so it ends the sweep at once.
    assign last_o = (cur_i == stop_i) || (step_i == '0);

    // Take the stepped value only when it stays on the near side of stop.
    always_comb begin
        next_o = stop_i;
        if (dir_up_i) begin
            if (!sum_w[FW] && (sum_w[FW-1:0] <= stop_i)) begin
                next_o = sum_w[FW-1:0];
            end
        end else begin
            if (!diff_w[FW] && (diff_w[FW-1:0] >= stop_i)) begin
                next_o = diff_w[FW-1:0];
            end
        end
    end

endmodule

// File: rtl/sweep_controller.sv
// Frequency sweep controller for a DDS. Latches a sweep configuration on
// launch, steps the frequency word with a per-point dwell and reports
// sweep-pass boundaries and completion.
module sweep_controller
    import afg_sweep_pkg::*;
#(
    parameter int FW = FW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [FW-1:0] Start_Freq,
    input  logic [FW-1:0] Stop_Freq,
    input  logic [FW-1:0] Step,
    input  logic [DW-1:0] Dwell,
    input  logic          Continuous,
    input  logic          Start,
    input  logic          Abort,
    output logic [FW-1:0] Freq_Word,
    output logic          Freq_Valid,
    output logic          Sweep_Sync,
    output logic          Busy,
    output logic          Done
);

    sweep_state_t  state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic          valid_q, valid_d;
    logic          sync_q, sync_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] start_q, start_d;
    logic [FW-1:0] stop_q, stop_d;
    logic [FW-1:0] step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          cont_q, cont_d;
    logic          dir_up_q, dir_up_d;

    logic [FW-1:0] next_freq_w;
    logic          last_w;

    // Remaining cycles after the first one of a point; a dwell of 0 acts as 1.
    function automatic logic [DW-1:0] dwell_m1(input logic [DW-1:0] d);
        return (d == '0) ? '0 : (d - DW'(1));
    endfunction

    sweep_next_freq #(
        .FW(FW)
    ) u_next (
        .cur_i   (freq_q),
        .step_i  (step_q),
        .stop_i  (stop_q),
        .dir_up_i(dir_up_q),
        .next_o  (next_freq_w),
        .last_o  (last_w)
    );

    // Next-state logic: launch, dwell countdown, stepping, reload and abort.
    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        valid_d  = 1'b0;
        sync_d   = 1'b0;
        cnt_d    = cnt_q;
        start_d  = start_q;
        stop_d   = stop_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cont_d   = cont_q;
        dir_up_d = dir_up_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    state_d  = ST_DWELL;
                    start_d  = Start_Freq;
                    stop_d   = Stop_Freq;
                    step_d   = Step;
                    dwell_d  = Dwell;
                    cont_d   = Continuous;
                    dir_up_d = (Start_Freq <= Stop_Freq);
                    freq_d   = Start_Freq;
                    valid_d  = 1'b1;
                    sync_d   = 1'b1;
                    cnt_d    = dwell_m1(Dwell);
                end
            end
            ST_DWELL: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                end else if (last_w) begin
                    if (cont_q) begin
                        freq_d  = start_q;
                        valid_d = 1'b1;
                        sync_d  = 1'b1;
                        cnt_d   = dwell_m1(dwell_q);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    freq_d  = next_freq_w;
                    valid_d = 1'b1;
                    cnt_d   = dwell_m1(dwell_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output and configuration registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            freq_q   <= '0;
            valid_q  <= 1'b0;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cont_q   <= 1'b0;
            dir_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cont_q   <= cont_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign Freq_Word  = freq_q;
    assign Freq_Valid = valid_q;
    assign Sweep_Sync = sync_q;
    assign Busy       = (state_q == ST_DWELL);
    assign Done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_sweep_controller.sv
// Directed bench for sweep_controller. Expected frequency points are queued
// as each sweep is launched and consumed whenever Freq_Valid pulses.
module tb_sweep_controller;

    localparam int FW = 48;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic [FW-1:0] Start_Freq = '0;
    logic [FW-1:0] Stop_Freq = '0;
    logic [FW-1:0] Step = '0;
    logic [DW-1:0] Dwell = '0;
    logic          Continuous = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [FW-1:0] Freq_Word;
    logic          Freq_Valid;
    logic          Sweep_Sync;
    logic          Busy;
    logic          Done;

    typedef struct {
        logic [FW-1:0] f;
        logic          s;
        int            gap;
    } exp_t;

    exp_t          sb[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            mon_cyc = 0;
    int            last_v = 0;
    logic [FW-1:0] prev_f = '0;
    logic          prev_rst = 1'b1;

    sweep_controller #(
        .FW(FW),
        .DW(DW)
    ) dut (
        .Clock     (clk),
        .Reset     (Reset),
        .Start_Freq(Start_Freq),
        .Stop_Freq (Stop_Freq),
        .Step      (Step),
        .Dwell     (Dwell),
        .Continuous(Continuous),
        .Start     (Start),
        .Abort     (Abort),
        .Freq_Word (Freq_Word),
        .Freq_Valid(Freq_Valid),
        .Sweep_Sync(Sweep_Sync),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [FW-1:0] f, input logic s, input int g);
        exp_t e;
        e.f = f;
        e.s = s;
        e.gap = g;
        sb.push_back(e);
    endtask

    // Drive one launch; config inputs are scrambled afterwards to prove latching.
    task automatic launch(input logic [FW-1:0] sf, input logic [FW-1:0] pf,
                          input logic [FW-1:0] st, input logic [DW-1:0] dw,
                          input logic co);
        @(posedge clk); #1;
        Start_Freq = sf; Stop_Freq = pf; Step = st; Dwell = dw; Continuous = co;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        Start_Freq = {16'h0, $urandom()};
        Stop_Freq = {16'h0, $urandom()};
        Step = FW'($urandom_range(1, 50));
        Dwell = DW'($urandom_range(5, 9));
        Continuous = ~co;
    endtask

    // Edges counted from the edge that samples Start until Done is visible.
    task automatic run_until_done(input string tag, input int max, output int c);
        c = 1;
        while (!Done && c < max) begin
            @(posedge clk); #1;
            c++;
        end
        chk(tag, 64'(Done), 64'(1));
    endtask

    // Scoreboard consumer and hold-between-points monitor.
    always @(negedge clk) begin
        exp_t e;
        mon_cyc++;
        if (Freq_Valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_point", 64'(Freq_Word), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("freq_word", 64'(Freq_Word), 64'(e.f));
                chk("sweep_sync", 64'(Sweep_Sync), 64'(e.s));
                if (e.gap >= 0) chk("dwell_gap", 64'(mon_cyc - last_v), 64'(e.gap));
            end
            last_v = mon_cyc;
        end else if (!Reset && !prev_rst) begin
            chk("hold_word", 64'(Freq_Word), 64'(prev_f));
            chk("sync_no_valid", 64'(Sweep_Sync), 64'(0));
        end
        prev_f = Freq_Word;
        prev_rst = Reset;
    end

    initial begin
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word", 64'(Freq_Word), 64'(0));
        chk("rst_valid", 64'(Freq_Valid), 64'(0));
        chk("rst_sync", 64'(Sweep_Sync), 64'(0));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        Reset = 1'b0;

        // Up sweep, dwell 2
        push(48'd100, 1'b1, -1); push(48'd110, 1'b0, 2);
        push(48'd120, 1'b0, 2);  push(48'd130, 1'b0, 2);
        launch(48'd100, 48'd130, 48'd10, 32'd2, 1'b0);
        chk("up_busy", 64'(Busy), 64'(1));
        run_until_done("up_done", 40, c);
        chk("up_done_latency", 64'(c), 64'(9));
        chk("up_done_busy", 64'(Busy), 64'(0));
        chk("up_done_word", 64'(Freq_Word), 64'(130));
        @(posedge clk); #1;
        chk("up_done_pulse", 64'(Done), 64'(0));
        chk("up_sb_empty", 64'(sb.size()), 64'(0));

        // Clamp to stop, with Start while busy and Start in DONE ignored
        push(48'd100, 1'b1, -1); push(48'd110, 1'b0, 1);
        push(48'd120, 1'b0, 1);  push(48'd125, 1'b0, 1);
        launch(48'd100, 48'd125, 48'd10, 32'd1, 1'b0);
        Start_Freq = 48'd999; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        run_until_done("clamp_done", 40, c);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("start_in_done_busy", 64'(Busy), 64'(0));
        chk("start_in_done_valid", 64'(Freq_Valid), 64'(0));
        chk("clamp_sb_empty", 64'(sb.size()), 64'(0));

        // Down sweep
        push(48'd16, 1'b1, -1); push(48'd10, 1'b0, 1); push(48'd4, 1'b0, 1);
        launch(48'd16, 48'd4, 48'd6, 32'd1, 1'b0);
        run_until_done("down_done", 40, c);
        chk("down_done_word", 64'(Freq_Word), 64'(4));

        // Down with borrow
        push(48'd5, 1'b1, -1); push(48'd1, 1'b0, 1);
        launch(48'd5, 48'd1, 48'd10, 32'd1, 1'b0);
        run_until_done("borrow_done", 40, c);

        // Up with carry-out
        push(48'hFFFF_FFFF_FFF0, 1'b1, -1); push(48'hFFFF_FFFF_FFFF, 1'b0, 3);
        launch(48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFFF, 48'h20, 32'd3, 1'b0);
        run_until_done("carry_done", 40, c);
        chk("carry_done_word", 64'(Freq_Word), 64'hFFFF_FFFF_FFFF);

        // Continuous sweep then abort on a "1" point
        push(48'd0, 1'b1, -1);
        for (int i = 1; i < 8; i++) push(FW'(i % 3), (i % 3) == 0, 1);
        launch(48'd0, 48'd2, 48'd1, 32'd1, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        chk("abort_busy", 64'(Busy), 64'(0));
        chk("abort_valid", 64'(Freq_Valid), 64'(0));
        chk("abort_word", 64'(Freq_Word), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 64'(Done), 64'(0));
            @(posedge clk); #1;
        end
        chk("cont_sb_empty", 64'(sb.size()), 64'(0));

        // Step 0 with Dwell 0: one point held one cycle
        push(48'd50, 1'b1, -1);
        launch(48'd50, 48'd80, 48'd0, 32'd0, 1'b0);
        run_until_done("step0_done", 20, c);
        chk("step0_latency", 64'(c), 64'(2));
        chk("step0_word", 64'(Freq_Word), 64'(50));

        // Start equal to stop
        push(48'd77, 1'b1, -1);
        launch(48'd77, 48'd77, 48'd5, 32'd2, 1'b0);
        run_until_done("equal_done", 20, c);
        chk("equal_latency", 64'(c), 64'(3));

        // Start and Abort together: no launch
        @(posedge clk); #1;
        Start_Freq = 48'd300; Stop_Freq = 48'd400; Step = 48'd1; Dwell = 32'd1;
        Start = 1'b1; Abort = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; Abort = 1'b0;
        chk("start_abort_busy", 64'(Busy), 64'(0));
        chk("start_abort_valid", 64'(Freq_Valid), 64'(0));
        @(posedge clk); #1;
        chk("start_abort_busy2", 64'(Busy), 64'(0));

        // Reset mid-sweep
        push(48'd1000, 1'b1, -1);
        launch(48'd1000, 48'd2000, 48'd1, 32'd4, 1'b0);
        @(posedge clk); #1;
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        chk("midrst_word", 64'(Freq_Word), 64'(0));
        chk("midrst_valid", 64'(Freq_Valid), 64'(0));
        chk("midrst_sync", 64'(Sweep_Sync), 64'(0));
        chk("midrst_busy", 64'(Busy), 64'(0));
        chk("midrst_done", 64'(Done), 64'(0));
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_idle_busy", 64'(Busy), 64'(0));
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
